// File: rtl/jt12_pg_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : jt12_pg_sched
// Description : Time-multiplexed frequency scheduler for the phase generator.
//               Holds the per-channel block/F-number registers, including
//               high-byte latching and the channel-3 special-mode operator
//               frequencies. Walks the 24 operator slots, drives a shared
//               phase incrementer and registers its result per slot.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module jt12_pg_sched #(
    parameter int NUM_CH = 6,
    parameter int NUM_OP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        wr,
    input  logic [3:0]  wr_addr,
    input  logic        wr_hi,
    input  logic [7:0]  din,
    input  logic        ch3_mode,
    input  logic [7:0]  pm_offset,
    output logic [2:0]  inc_block,
    output logic [10:0] inc_fnum,
    output logic [7:0]  inc_pm,
    input  logic [16:0] inc_phinc,
    output logic [16:0] phinc,
    output logic [4:0]  phinc_slot,
    output logic [2:0]  phinc_ch,
    output logic [1:0]  phinc_op,
    output logic        phinc_valid
);

    localparam int NUM_SP   = 3;
    localparam logic [2:0] CH_LAST = 3'(NUM_CH - 1);
    localparam logic [1:0] OP_LAST = 2'(NUM_OP - 1);
    localparam logic [2:0] CH_SPECIAL = 3'd2;

    // Frequency storage: each entry is {block[2:0], fnum[10:0]}
    logic [13:0] ch_reg_q [NUM_CH];
    logic [13:0] ch_reg_d [NUM_CH];
    logic [13:0] sp_reg_q [NUM_SP];
    logic [13:0] sp_reg_d [NUM_SP];
    // High-byte latches: {block[2:0], fnum[10:8]}
    logic [5:0]  latch_a_q, latch_a_d;
    logic [5:0]  latch_b_q, latch_b_d;

    // Slot counters
    logic [2:0]  ch_cnt_q, ch_cnt_d;
    logic [1:0]  op_cnt_q, op_cnt_d;

    // Select stage
    logic [2:0]  sel_block_q, sel_block_d;
    logic [10:0] sel_fnum_q, sel_fnum_d;
    logic [7:0]  sel_pm_q, sel_pm_d;
    logic [2:0]  sel_ch_q, sel_ch_d;
    logic [1:0]  sel_op_q, sel_op_d;

    // Capture stage
    logic        primed_q, primed_d;
    logic [16:0] phinc_q, phinc_d;
    logic [4:0]  phinc_slot_q, phinc_slot_d;
    logic [2:0]  phinc_ch_q, phinc_ch_d;
    logic [1:0]  phinc_op_q, phinc_op_d;
    logic        phinc_valid_q, phinc_valid_d;

    logic        w_addr_ch;
    logic        w_addr_sp;
    logic        w_use_sp;
    logic [13:0] w_sel_reg;
    logic [4:0]  w_sel_slot;

    assign w_addr_ch  = (wr_addr <= 4'd5);
    assign w_addr_sp  = (wr_addr >= 4'd8) && (wr_addr <= 4'd10);
    assign w_use_sp   = ch3_mode && (ch_cnt_q == CH_SPECIAL) && (op_cnt_q != 2'd3);
    assign w_sel_slot = 5'(sel_op_q) * 5'(NUM_CH) + 5'(sel_ch_q);

    // Frequency source for the slot currently pointed at by the counters
    always_comb begin
        w_sel_reg = ch_reg_q[ch_cnt_q];
        if (w_use_sp) begin
            w_sel_reg = sp_reg_q[op_cnt_q];
        end
    end

    // Register writes: high byte only loads the latch, low byte commits
    always_comb begin
        ch_reg_d  = ch_reg_q;
        sp_reg_d  = sp_reg_q;
        latch_a_d = latch_a_q;
        latch_b_d = latch_b_q;
        if (wr) begin
            if (wr_hi) begin
                if (w_addr_ch) begin
                    latch_a_d = din[5:0];
                end else if (w_addr_sp) begin
                    latch_b_d = din[5:0];
                end
            end else begin
                if (w_addr_ch) begin
                    ch_reg_d[wr_addr[2:0]] = {latch_a_q, din};
                end else if (w_addr_sp) begin
                    sp_reg_d[wr_addr[1:0]] = {latch_b_q, din};
                end
            end
        end
    end

    // Slot walk, selection and incrementer result capture
    always_comb begin
        ch_cnt_d      = ch_cnt_q;
        op_cnt_d      = op_cnt_q;
        sel_block_d   = sel_block_q;
        sel_fnum_d    = sel_fnum_q;
        sel_pm_d      = sel_pm_q;
        sel_ch_d      = sel_ch_q;
        sel_op_d      = sel_op_q;
        primed_d      = primed_q;
        phinc_d       = phinc_q;
        phinc_slot_d  = phinc_slot_q;
        phinc_ch_d    = phinc_ch_q;
        phinc_op_d    = phinc_op_q;
        phinc_valid_d = 1'b0;
        if (cen) begin
            if (ch_cnt_q == CH_LAST) begin
                ch_cnt_d = 3'd0;
                op_cnt_d = (op_cnt_q == OP_LAST) ? 2'd0 : op_cnt_q + 2'd1;
            end else begin
                ch_cnt_d = ch_cnt_q + 3'd1;
            end
            sel_block_d = w_sel_reg[13:11];
            sel_fnum_d  = w_sel_reg[10:0];
            sel_pm_d    = pm_offset;
            sel_ch_d    = ch_cnt_q;
            sel_op_d    = op_cnt_q;
            primed_d    = 1'b1;
            // The select stage is empty until the first cen after reset
            if (primed_q) begin
                phinc_d       = inc_phinc;
                phinc_slot_d  = w_sel_slot;
                phinc_ch_d    = sel_ch_q;
                phinc_op_d    = sel_op_q;
                phinc_valid_d = 1'b1;
            end
        end
    end

    // State update with synchronous reset taking priority over wr and cen
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) ch_reg_q[i] <= '0;
            for (int i = 0; i < NUM_SP; i++) sp_reg_q[i] <= '0;
            latch_a_q     <= '0;
            latch_b_q     <= '0;
            ch_cnt_q      <= '0;
            op_cnt_q      <= '0;
            sel_block_q   <= '0;
            sel_fnum_q    <= '0;
            sel_pm_q      <= '0;
            sel_ch_q      <= '0;
            sel_op_q      <= '0;
            primed_q      <= 1'b0;
            phinc_q       <= '0;
            phinc_slot_q  <= '0;
            phinc_ch_q    <= '0;
            phinc_op_q    <= '0;
            phinc_valid_q <= 1'b0;
        end else begin
            ch_reg_q      <= ch_reg_d;
            sp_reg_q      <= sp_reg_d;
            latch_a_q     <= latch_a_d;
            latch_b_q     <= latch_b_d;
            ch_cnt_q      <= ch_cnt_d;
            op_cnt_q      <= op_cnt_d;
            sel_block_q   <= sel_block_d;
            sel_fnum_q    <= sel_fnum_d;
            sel_pm_q      <= sel_pm_d;
            sel_ch_q      <= sel_ch_d;
            sel_op_q      <= sel_op_d;
            primed_q      <= primed_d;
            phinc_q       <= phinc_d;
            phinc_slot_q  <= phinc_slot_d;
            phinc_ch_q    <= phinc_ch_d;
            phinc_op_q    <= phinc_op_d;
            phinc_valid_q <= phinc_valid_d;
        end
    end

    assign inc_block   = sel_block_q;
    assign inc_fnum    = sel_fnum_q;
    assign inc_pm      = sel_pm_q;
    assign phinc       = phinc_q;
    assign phinc_slot  = phinc_slot_q;
    assign phinc_ch    = phinc_ch_q;
    assign phinc_op    = phinc_op_q;
    assign phinc_valid = phinc_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_jt12_pg_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_jt12_pg_sched
// Description : Directed self-checking bench for jt12_pg_sched. A simple
//               stand-in incrementer ((fnum + sext(pm)) << block) closes the
//               loop so captured increments can be predicted by hand.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_jt12_pg_sched;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        wr;
    logic [3:0]  wr_addr;
    logic        wr_hi;
    logic [7:0]  din;
    logic        ch3_mode;
    logic [7:0]  pm_offset;
    logic [2:0]  inc_block;
    logic [10:0] inc_fnum;
    logic [7:0]  inc_pm;
    logic [16:0] inc_phinc;
    logic [16:0] phinc;
    logic [4:0]  phinc_slot;
    logic [2:0]  phinc_ch;
    logic [1:0]  phinc_op;
    logic        phinc_valid;

    int n_checks;
    int n_fail;
    int sel_slot;

    jt12_pg_sched #(.NUM_CH(6), .NUM_OP(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .wr         (wr),
        .wr_addr    (wr_addr),
        .wr_hi      (wr_hi),
        .din        (din),
        .ch3_mode   (ch3_mode),
        .pm_offset  (pm_offset),
        .inc_block  (inc_block),
        .inc_fnum   (inc_fnum),
        .inc_pm     (inc_pm),
        .inc_phinc  (inc_phinc),
        .phinc      (phinc),
        .phinc_slot (phinc_slot),
        .phinc_ch   (phinc_ch),
        .phinc_op   (phinc_op),
        .phinc_valid(phinc_valid)
    );

    function automatic logic [16:0] pg_model(input logic [2:0] b, input logic [10:0] f,
                                             input logic [7:0] p);
        logic [16:0] v;
        v = {6'd0, f} + {{9{p[7]}}, p};
        return v << b;
    endfunction

    assign inc_phinc = pg_model(inc_block, inc_fnum, inc_pm);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cen = 1'b1;
        tick();
        cen = 1'b0;
        sel_slot = (sel_slot + 1) % 24;
    endtask

    task automatic advance_sel(input int target);
        for (int i = 0; i < 24 && sel_slot != target; i++) step();
    endtask

    task automatic do_write(input logic [3:0] a, input logic hi, input logic [7:0] d);
        wr = 1'b1; wr_addr = a; wr_hi = hi; din = d;
        tick();
        wr = 1'b0;
    endtask

    initial begin
        int nvalid;
        n_checks = 0; n_fail = 0; sel_slot = 23;
        rst = 1'b1; cen = 1'b0; wr = 1'b0; wr_addr = 4'd0; wr_hi = 1'b0;
        din = 8'd0; ch3_mode = 1'b0; pm_offset = 8'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_phinc", 32'(phinc), 32'h0);
        chk("rst_valid", 32'(phinc_valid), 32'h0);
        chk("rst_slot", 32'(phinc_slot), 32'h0);

        // 25 cens from reset: priming, then slots 0..23 in order
        for (int k = 1; k <= 25; k++) begin
            step();
            if (k == 1) begin
                chk("prime_valid", 32'(phinc_valid), 32'h0);
            end else begin
                chk("seq_valid", 32'(phinc_valid), 32'h1);
                chk("seq_slot", 32'(phinc_slot), 32'((k - 2) % 24));
                chk("seq_ch", 32'(phinc_ch), 32'(((k - 2) % 24) % 6));
                chk("seq_op", 32'(phinc_op), 32'(((k - 2) % 24) / 6));
                chk("seq_phinc", 32'(phinc), 32'h0);
            end
        end

        // ch1 = block 4, fnum 0x269 via latch + commit
        do_write(4'd1, 1'b1, 8'h22);
        do_write(4'd1, 1'b0, 8'h69);
        step();
        chk("ch1_block", 32'(inc_block), 32'h4);
        chk("ch1_fnum", 32'(inc_fnum), 32'h269);
        step();
        chk("ch1_phinc", 32'(phinc), 32'h2690);
        chk("ch1_slot", 32'(phinc_slot), 32'h1);

        // special op1 = block 2 fnum 0x100; ch2 = block 1 fnum 0x300
        do_write(4'd9, 1'b1, 8'h11);
        do_write(4'd9, 1'b0, 8'h00);
        do_write(4'd2, 1'b1, 8'h0B);
        do_write(4'd2, 1'b0, 8'h00);
        ch3_mode = 1'b1;
        advance_sel(8);
        chk("sp8_block", 32'(inc_block), 32'h2);
        chk("sp8_fnum", 32'(inc_fnum), 32'h100);
        step();
        chk("sp8_phinc", 32'(phinc), 32'h400);
        chk("sp8_slot", 32'(phinc_slot), 32'd8);
        chk("sp8_ch", 32'(phinc_ch), 32'd2);
        chk("sp8_op", 32'(phinc_op), 32'd1);
        advance_sel(20);
        chk("sp20_block", 32'(inc_block), 32'h1);
        chk("sp20_fnum", 32'(inc_fnum), 32'h300);
        step();
        chk("sp20_phinc", 32'(phinc), 32'h600);
        chk("sp20_slot", 32'(phinc_slot), 32'd20);
        ch3_mode = 1'b0;
        advance_sel(8);
        chk("nosp8_block", 32'(inc_block), 32'h1);
        chk("nosp8_fnum", 32'(inc_fnum), 32'h300);

        // commit to ch0 in the same cycle slot 0 is selected
        advance_sel(23);
        cen = 1'b1; wr = 1'b1; wr_hi = 1'b0; wr_addr = 4'd0; din = 8'h55;
        tick();
        cen = 1'b0; wr = 1'b0;
        sel_slot = 0;
        chk("old_block", 32'(inc_block), 32'h0);
        chk("old_fnum", 32'(inc_fnum), 32'h0);
        step();
        advance_sel(0);
        chk("new_block", 32'(inc_block), 32'h1);
        chk("new_fnum", 32'(inc_fnum), 32'h355);
        step();
        chk("new_phinc", 32'(phinc), 32'h6AA);

        // cen held low: nothing moves
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (phinc_valid) nvalid++;
        end
        chk("hold_nvalid", 32'(nvalid), 32'h0);
        chk("hold_slot", 32'(phinc_slot), 32'h0);
        step();
        chk("resume_valid", 32'(phinc_valid), 32'h1);
        chk("resume_slot", 32'(phinc_slot), 32'h1);
        chk("resume_phinc", 32'(phinc), 32'h2690);

        // pm offset sampled with its own slot only
        pm_offset = 8'hFC;
        step();
        chk("pm3_inc", 32'(inc_pm), 32'hFC);
        pm_offset = 8'h07;
        step();
        chk("pm4_inc", 32'(inc_pm), 32'h07);
        chk("pm3_phinc", 32'(phinc), 32'h1FFFC);
        chk("pm3_slot", 32'(phinc_slot), 32'd3);
        pm_offset = 8'h00;
        step();
        chk("pm4_phinc", 32'(phinc), 32'h7);
        chk("pm4_slot", 32'(phinc_slot), 32'd4);
        chk("pm5_inc", 32'(inc_pm), 32'h0);

        // reset mid-sequence with cen and wr also high
        rst = 1'b1; cen = 1'b1; wr = 1'b1; wr_hi = 1'b1; wr_addr = 4'd0; din = 8'h3F;
        tick();
        rst = 1'b0; cen = 1'b0; wr = 1'b0;
        sel_slot = 23;
        chk("mrst_phinc", 32'(phinc), 32'h0);
        chk("mrst_valid", 32'(phinc_valid), 32'h0);
        chk("mrst_slot", 32'(phinc_slot), 32'h0);
        chk("mrst_fnum", 32'(inc_fnum), 32'h0);
        step();
        chk("mrst_prime", 32'(phinc_valid), 32'h0);
        chk("mrst_ch0", 32'(inc_fnum), 32'h0);
        step();
        chk("mrst_valid1", 32'(phinc_valid), 32'h1);
        chk("mrst_slot0", 32'(phinc_slot), 32'h0);
        chk("mrst_phinc0", 32'(phinc), 32'h0);

        // unused address leaves the (cleared) latch alone
        do_write(4'd6, 1'b1, 8'h3F);
        do_write(4'd1, 1'b0, 8'h69);
        step();
        advance_sel(1);
        chk("unused_block", 32'(inc_block), 32'h0);
        chk("unused_fnum", 32'(inc_fnum), 32'h069);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
